// File: rtl/mem_loader_pkg.sv
// ============================================================================
// Module : mem_loader_pkg
// Brief  : Shared types and constants for the boot-time RAM image loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_loader_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned WORD_W             = 16;
    localparam int unsigned DEFAULT_MEM_DEPTH  = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

endpackage : mem_loader_pkg

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module : mem_loader
// Brief  : Receives a length-prefixed, XOR-checksummed byte frame and writes
//          its big-endian 16-bit words sequentially into RAM port A.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = WORD_W,
    parameter int unsigned           MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_W-1:0]     words_written
);

    state_t                  r_state;
    logic                    r_rx_ready;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_din;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [WORD_W-1:0]       r_words_written;
    logic [WORD_W-1:0]       r_len;
    logic [BYTE_W-1:0]       r_hi;
    logic [BYTE_W-1:0]       r_acc;

    logic                    w_accept;
    logic [WORD_W-1:0]       w_len;
    logic                    w_len_too_big;

    always_comb begin
        w_accept      = rx_valid && r_rx_ready;
        w_len         = {r_hi, rx_data};
        w_len_too_big = 32'(w_len) > MEM_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rx_ready      <= 1'b0;
            r_mem_en        <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= BASE_ADDR;
            r_mem_din       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= '0;
            r_len           <= '0;
            r_hi            <= '0;
            r_acc           <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_done          <= 1'b0;
                        r_error         <= 1'b0;
                        r_words_written <= '0;
                        r_acc           <= '0;
                        r_busy          <= 1'b1;
                        r_rx_ready      <= 1'b1;
                        r_state         <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_accept) begin
                        r_hi    <= rx_data;
                        r_acc   <= r_acc ^ rx_data;
                        r_state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        r_acc <= r_acc ^ rx_data;
                        if (w_len_too_big) begin
                            r_rx_ready <= 1'b0;
                            r_state    <= ERROR;
                        end else if (w_len == '0) begin
                            r_state <= CHK;
                        end else begin
                            r_state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (w_accept) begin
                        r_hi    <= rx_data;
                        r_acc   <= r_acc ^ rx_data;
                        r_state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    // Write is issued from registers so it lands exactly one cycle after the low byte.
                    if (w_accept) begin
                        r_acc           <= r_acc ^ rx_data;
                        r_mem_en        <= 1'b1;
                        r_mem_we        <= 1'b1;
                        r_mem_addr      <= BASE_ADDR + ADDR_WIDTH'(r_words_written);
                        r_mem_din       <= DATA_WIDTH'({r_hi, rx_data});
                        r_words_written <= r_words_written + 1'b1;
                        r_rx_ready      <= 1'b0;
                        r_state         <= WRITE;
                    end
                end
                WRITE: begin
                    r_rx_ready <= 1'b1;
                    r_state    <= (r_words_written == r_len) ? CHK : DATA_HI;
                end
                CHK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        r_state    <= (rx_data == r_acc) ? DONE : ERROR;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                ERROR: begin
                    r_error <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready      = r_rx_ready;
    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_din       = r_mem_din;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words_written;

endmodule : mem_loader

`default_nettype wire
